// File: rtl/lector_serie_buffer_if.sv
// Read-side buffer port and narrow output stream used by lector_serie_buffer.
// master is the serializer side of both links.
interface lector_buf_if #(
    parameter int WIDTH = 64
);
    logic             vacia;
    logic             delecion;
    logic [WIDTH-1:0] dato;

    modport master (
        input  vacia,
        input  dato,
        output delecion
    );

    modport slave (
        output vacia,
        output dato,
        input  delecion
    );
endinterface

interface lector_stream_if #(
    parameter int W = 16
);
    logic         valido;
    logic         listo;
    logic [W-1:0] dato;
    logic         ultimo;

    modport master (
        output valido,
        output dato,
        output ultimo,
        input  listo
    );

    modport slave (
        input  valido,
        input  dato,
        input  ultimo,
        output listo
    );
endinterface

// File: rtl/lector_serie_buffer.sv
// Pops words from the circular buffer and serializes them LSB slice first.
// Back-to-back words reload in the last-beat cycle, so there is no bubble.
module lector_serie_buffer #(
    parameter int WIDTH     = 64,
    parameter int OUT_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   habilitar_i,
    lector_buf_if.master           buf_rd,
    lector_stream_if.master        salida,
    output logic [15:0]            palabras_o
);
    localparam int BEATS = WIDTH / OUT_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH-1:0]   shift_d;
    logic [CNT_W-1:0]   beat_q;
    logic [CNT_W-1:0]   beat_d;
    logic [15:0]        palabras_q;
    logic [15:0]        palabras_d;
    logic               pop;
    logic               puede_pop;
    logic               enviando;
    logic               xfer;
    logic               ultimo_beat;

    assign enviando    = (state_q == SEND);
    assign xfer        = enviando & salida.listo;
    assign ultimo_beat = (beat_q == LAST);
    assign puede_pop   = habilitar_i & ~buf_rd.vacia;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            beat_q     <= '0;
            palabras_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            beat_q     <= beat_d;
            palabras_q <= palabras_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        beat_d     = beat_q;
        palabras_d = palabras_q;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (puede_pop) begin
                    pop     = 1'b1;
                    shift_d = buf_rd.dato;
                    beat_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (ultimo_beat) begin
                        palabras_d = palabras_q + 16'd1;
                        // Reload in the same cycle to keep the stream gapless.
                        if (puede_pop) begin
                            pop     = 1'b1;
                            shift_d = buf_rd.dato;
                            beat_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        shift_d = shift_q >> OUT_WIDTH;
                        beat_d  = beat_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    // The pop strobe is combinational, so gate it with reset explicitly.
    assign buf_rd.delecion = pop & rstn_i;

    assign salida.valido = enviando;
    assign salida.dato   = enviando ? shift_q[OUT_WIDTH-1:0] : '0;
    assign salida.ultimo = enviando & ultimo_beat;
    assign palabras_o    = palabras_q;
endmodule

// File: tb/tb_lector_serie_buffer.sv
// Directed bench for lector_serie_buffer with a queue model of the buffer.
// A second BEATS=1 instance covers the single-beat-per-word case.
module tb_lector_serie_buffer;
    logic        clk;
    logic        rstn;
    logic        hab;
    logic        hab2;
    logic [15:0] pal;
    logic [15:0] pal2;

    lector_buf_if    #(.WIDTH(64)) rd ();
    lector_stream_if #(.W(16))     st ();
    lector_buf_if    #(.WIDTH(16)) rd1 ();
    lector_stream_if #(.W(16))     st1 ();

    lector_serie_buffer #(.WIDTH(64), .OUT_WIDTH(16)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .habilitar_i (hab),
        .buf_rd      (rd),
        .salida      (st),
        .palabras_o  (pal)
    );

    lector_serie_buffer #(.WIDTH(16), .OUT_WIDTH(16)) dut1 (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .habilitar_i (hab2),
        .buf_rd      (rd1),
        .salida      (st1),
        .palabras_o  (pal2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [63:0] fifo[$];

    typedef struct {
        logic        psh;
        logic [63:0] w;
        logic        hab;
        logic        lis;
        logic        del;
        logic        val;
        logic [15:0] dat;
        logic        ult;
        logic [15:0] pal;
    } vec_t;

    vec_t v[$];

    function automatic vec_t mk(
        input logic psh, input logic [63:0] w,
        input logic h, input logic l,
        input logic d, input logic va,
        input logic [15:0] dt, input logic u,
        input logic [15:0] p
    );
        vec_t r;
        r.psh = psh; r.w = w; r.hab = h; r.lis = l;
        r.del = d; r.val = va; r.dat = dt; r.ult = u;
        r.pal = p;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_buf();
        rd.vacia = (fifo.size() == 0);
        rd.dato  = (fifo.size() == 0) ? 64'hBAD0_BAD0_BAD0_BAD0 : fifo[0];
    endtask

    task automatic tick(input logic h, input logic l,
                        input logic edel, input logic ev,
                        input logic [15:0] ed, input logic eu,
                        input logic [15:0] ep, input string nm);
        logic d;
        hab = h;
        st.listo = l;
        drive_buf();
        @(negedge clk);
        d = rd.delecion;
        chk({nm, ".del"}, 64'(d), 64'(edel));
        chk({nm, ".val"}, 64'(st.valido), 64'(ev));
        chk({nm, ".dat"}, 64'(st.dato), 64'(ed));
        chk({nm, ".ult"}, 64'(st.ultimo), 64'(eu));
        chk({nm, ".pal"}, 64'(pal), 64'(ep));
        @(posedge clk);
        if (d) void'(fifo.pop_front());
        #1;
        drive_buf();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // single word, full speed
        v.push_back(mk(0, 0, 1, 1, 1, 0, 16'h0000, 0, 0));
        v.push_back(mk(0, 0, 1, 1, 0, 1, 16'h1111, 0, 0));
        v.push_back(mk(0, 0, 1, 1, 0, 1, 16'h2222, 0, 0));
        v.push_back(mk(0, 0, 1, 1, 0, 1, 16'h3333, 0, 0));
        v.push_back(mk(0, 0, 1, 1, 0, 1, 16'h4444, 1, 0));
        v.push_back(mk(0, 0, 1, 1, 0, 0, 16'h0000, 0, 1));
        // three words back to back
        v.push_back(mk(1, 64'hB003_B002_B001_B000, 1, 1, 1, 0, 16'h0000, 0, 1));
        v.push_back(mk(1, 64'hC003_C002_C001_C000, 1, 1, 0, 1, 16'hB000, 0, 1));
        v.push_back(mk(1, 64'hD003_D002_D001_D000, 1, 1, 0, 1, 16'hB001, 0, 1));
        v.push_back(mk(0, 0, 1, 1, 0, 1, 16'hB002, 0, 1));
        v.push_back(mk(0, 0, 1, 1, 1, 1, 16'hB003, 1, 1));
        v.push_back(mk(0, 0, 1, 1, 0, 1, 16'hC000, 0, 2));
        v.push_back(mk(0, 0, 1, 1, 0, 1, 16'hC001, 0, 2));
        v.push_back(mk(0, 0, 1, 1, 0, 1, 16'hC002, 0, 2));
        v.push_back(mk(0, 0, 1, 1, 1, 1, 16'hC003, 1, 2));
        v.push_back(mk(0, 0, 1, 1, 0, 1, 16'hD000, 0, 3));
        v.push_back(mk(0, 0, 1, 1, 0, 1, 16'hD001, 0, 3));
        v.push_back(mk(0, 0, 1, 1, 0, 1, 16'hD002, 0, 3));
        v.push_back(mk(0, 0, 1, 1, 0, 1, 16'hD003, 1, 3));
        v.push_back(mk(0, 0, 1, 1, 0, 0, 16'h0000, 0, 4));
        // downstream stalls
        v.push_back(mk(1, 64'hE003_E002_E001_E000, 1, 1, 1, 0, 16'h0000, 0, 4));
        v.push_back(mk(1, 64'hF003_F002_F001_F000, 1, 1, 0, 1, 16'hE000, 0, 4));
        v.push_back(mk(0, 0, 1, 0, 0, 1, 16'hE001, 0, 4));
        v.push_back(mk(0, 0, 1, 0, 0, 1, 16'hE001, 0, 4));
        v.push_back(mk(0, 0, 1, 1, 0, 1, 16'hE001, 0, 4));
        v.push_back(mk(0, 0, 1, 0, 0, 1, 16'hE002, 0, 4));
        v.push_back(mk(0, 0, 1, 0, 0, 1, 16'hE002, 0, 4));
        v.push_back(mk(0, 0, 1, 1, 0, 1, 16'hE002, 0, 4));
        v.push_back(mk(0, 0, 1, 0, 0, 1, 16'hE003, 1, 4));
        v.push_back(mk(0, 0, 1, 0, 0, 1, 16'hE003, 1, 4));
        v.push_back(mk(0, 0, 1, 1, 1, 1, 16'hE003, 1, 4));
        v.push_back(mk(0, 0, 1, 0, 0, 1, 16'hF000, 0, 5));
        v.push_back(mk(0, 0, 1, 0, 0, 1, 16'hF000, 0, 5));
        v.push_back(mk(0, 0, 1, 1, 0, 1, 16'hF000, 0, 5));
        v.push_back(mk(0, 0, 1, 1, 0, 1, 16'hF001, 0, 5));
        v.push_back(mk(0, 0, 1, 1, 0, 1, 16'hF002, 0, 5));
        v.push_back(mk(0, 0, 1, 1, 0, 1, 16'hF003, 1, 5));
        v.push_back(mk(0, 0, 1, 1, 0, 0, 16'h0000, 0, 6));

        rstn = 1'b0;
        hab = 1'b1;
        st.listo = 1'b1;
        hab2 = 1'b0;
        rd1.vacia = 1'b1;
        rd1.dato = '0;
        st1.listo = 1'b1;
        fifo.push_back(64'h4444_3333_2222_1111);
        drive_buf();

        // reset held with a word waiting and pops enabled
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst.del", 64'(rd.delecion), 64'd0);
            chk("rst.val", 64'(st.valido), 64'd0);
            chk("rst.pal", 64'(pal), 64'd0);
        end
        @(posedge clk);
        #1 rstn = 1'b1;

        for (int i = 0; i < v.size(); i++) begin
            if (v[i].psh) fifo.push_back(v[i].w);
            tick(v[i].hab, v[i].lis, v[i].del, v[i].val,
                 v[i].dat, v[i].ult, v[i].pal, $sformatf("vec%0d", i));
        end

        // habilitar dropped mid-word with a second word queued
        fifo.push_back(64'hA003_A002_A001_A000);
        fifo.push_back(64'h7003_7002_7001_7000);
        tick(1, 1, 1, 0, 16'h0000, 0, 6, "hab.pop");
        tick(1, 1, 0, 1, 16'hA000, 0, 6, "hab.b0");
        tick(0, 1, 0, 1, 16'hA001, 0, 6, "hab.b1");
        tick(0, 1, 0, 1, 16'hA002, 0, 6, "hab.b2");
        tick(0, 1, 0, 1, 16'hA003, 1, 6, "hab.b3");
        tick(0, 1, 0, 0, 16'h0000, 0, 7, "hab.idle0");
        tick(0, 1, 0, 0, 16'h0000, 0, 7, "hab.idle1");
        chk("hab.left", 64'(fifo.size()), 64'd1);

        // reset while a word is partly sent
        tick(1, 1, 1, 0, 16'h0000, 0, 7, "mid.pop");
        tick(1, 1, 0, 1, 16'h7000, 0, 7, "mid.b0");
        tick(1, 1, 0, 1, 16'h7001, 0, 7, "mid.b1");
        rstn = 1'b0;
        #1;
        chk("mid.rst.val", 64'(st.valido), 64'd0);
        chk("mid.rst.dat", 64'(st.dato), 64'd0);
        chk("mid.rst.ult", 64'(st.ultimo), 64'd0);
        chk("mid.rst.pal", 64'(pal), 64'd0);
        fifo.push_back(64'h9003_9002_9001_9000);
        drive_buf();
        @(negedge clk);
        chk("mid.rst.del", 64'(rd.delecion), 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        tick(1, 1, 1, 0, 16'h0000, 0, 0, "post.pop");
        tick(1, 1, 0, 1, 16'h9000, 0, 0, "post.b0");
        tick(1, 1, 0, 1, 16'h9001, 0, 0, "post.b1");
        tick(1, 1, 0, 1, 16'h9002, 0, 0, "post.b2");
        tick(1, 1, 0, 1, 16'h9003, 1, 0, "post.b3");
        tick(1, 1, 0, 0, 16'h0000, 0, 1, "post.idle");

        // one beat per word
        hab2 = 1'b1;
        rd1.vacia = 1'b0;
        rd1.dato = 16'hAAAA;
        @(negedge clk);
        chk("b1.pop", 64'(rd1.delecion), 64'd1);
        chk("b1.val0", 64'(st1.valido), 64'd0);
        @(posedge clk);
        #1 rd1.dato = 16'hBBBB;
        @(negedge clk);
        chk("b1.dat0", 64'(st1.dato), 64'hAAAA);
        chk("b1.ult0", 64'(st1.ultimo), 64'd1);
        chk("b1.reload", 64'(rd1.delecion), 64'd1);
        @(posedge clk);
        #1 rd1.vacia = 1'b1;
        @(negedge clk);
        chk("b1.dat1", 64'(st1.dato), 64'hBBBB);
        chk("b1.ult1", 64'(st1.ultimo), 64'd1);
        chk("b1.nopop", 64'(rd1.delecion), 64'd0);
        chk("b1.pal1", 64'(pal2), 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("b1.idle", 64'(st1.valido), 64'd0);
        chk("b1.pal2", 64'(pal2), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
